// File: rtl/inst_dispatch.sv
// Instruction front end: buffers 28-bit words in a small FIFO and executes them in
// order as memory address bursts or compute start/done handshakes.
module inst_dispatch #(
  parameter int INST_WIDTH = 28,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_port,
  output logic                  mem_last,
  output logic                  op_valid,
  output logic [2:0]            op_code,
  output logic [3:0]            op_a,
  output logic [3:0]            op_b,
  output logic [3:0]            op_c,
  output logic [1:0]            op_mode,
  input  logic                  op_done,
  output logic                  busy,
  output logic                  err_illegal
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, MEM, DISPATCH, WAIT} state_t;

  state_t                r_state, w_nxt;
  logic [INST_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_rd, r_wr;
  logic [CW-1:0]         r_cnt;
  logic [INST_WIDTH-1:0] r_cur;
  logic [5:0]            r_k;
  logic                  r_mem_en, r_mem_we, r_mem_last, r_op_valid, r_busy, r_err;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [1:0]            r_mem_port, r_op_mode;
  logic [2:0]            r_op_code;
  logic [3:0]            r_op_a, r_op_b, r_op_c;

  logic [INST_WIDTH-1:0] w_head;
  logic [2:0]            w_opc;
  logic [5:0]            w_len;
  logic                  w_push, w_pop, w_illegal, w_unused;

  assign inst_ready = (r_cnt != CW'(FIFO_DEPTH));
  assign w_push     = inst_valid && inst_ready;
  assign w_pop      = (r_state == IDLE) && (r_cnt != '0);
  assign w_head     = r_fifo[r_rd];
  assign w_opc      = w_head[27:25];
  assign w_len      = r_cur[12:7];
  assign w_unused   = ^{w_head[24:13], w_head[6:0], r_cur[4:0]};

  always_comb begin
    w_nxt     = r_state;
    w_illegal = 1'b0;
    case (r_state)
      IDLE: if (w_pop) begin
        case (w_opc)
          3'b000, 3'b001: if (w_head[12:7] != 6'd0) w_nxt = MEM;
          3'b100, 3'b101, 3'b110: w_nxt = DISPATCH;
          default: w_illegal = 1'b1;
        endcase
      end
      MEM:      if (r_k == w_len - 6'd1) w_nxt = IDLE;
      DISPATCH: w_nxt = WAIT;
      WAIT:     if (op_done) w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Storage needs no reset: occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0; r_wr <= '0; r_cnt <= '0; r_cur <= '0; r_k <= '0;
      r_mem_en <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0; r_mem_port <= '0;
      r_mem_last <= 1'b0; r_op_valid <= 1'b0; r_op_code <= '0; r_op_a <= '0;
      r_op_b <= '0; r_op_c <= '0; r_op_mode <= '0; r_busy <= 1'b0; r_err <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) begin
        r_rd  <= r_rd + PW'(1);
        r_cur <= w_head;
        r_k   <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Beat outputs are produced one cycle behind the MEM state's beat index.
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_port <= '0;
      r_mem_last <= 1'b0;
      if (r_state == MEM) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= r_cur[25];
        r_mem_addr <= r_cur[13 +: ADDR_WIDTH] + ADDR_WIDTH'(r_k);
        r_mem_port <= r_cur[6:5];
        r_mem_last <= (r_k == w_len - 6'd1);
        r_k        <= r_k + 6'd1;
      end
      r_op_valid <= 1'b0;
      if (r_state == DISPATCH) begin
        r_op_valid <= 1'b1;
        r_op_code  <= r_cur[27:25];
        r_op_a     <= r_cur[24:21];
        r_op_b     <= r_cur[20:17];
        r_op_c     <= r_cur[16:13];
        r_op_mode  <= r_cur[12:11];
      end
      if (w_illegal) r_err <= 1'b1;
      r_busy <= (r_cnt != '0) || (r_state != IDLE);
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_port    = r_mem_port;
  assign mem_last    = r_mem_last;
  assign op_valid    = r_op_valid;
  assign op_code     = r_op_code;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign op_c        = r_op_c;
  assign op_mode     = r_op_mode;
  assign busy        = r_busy;
  assign err_illegal = r_err;
endmodule

// File: tb/tb_inst_dispatch.sv
// Bench for inst_dispatch: table of single-instruction vectors plus hand-written
// sequences for ordering, FIFO backpressure, illegal opcodes and mid-burst reset.
module tb_inst_dispatch;
  logic        clk = 1'b0, rst = 1'b1;
  logic [27:0] inst = '0;
  logic        inst_valid = 1'b0, inst_ready;
  logic        mem_en, mem_we, mem_last, op_valid, busy, err_illegal;
  logic [11:0] mem_addr;
  logic [1:0]  mem_port, op_mode;
  logic [2:0]  op_code;
  logic [3:0]  op_a, op_b, op_c;
  logic        op_done = 1'b0;

  always #5 clk = ~clk;

  inst_dispatch dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_port(mem_port),
    .mem_last(mem_last), .op_valid(op_valid), .op_code(op_code), .op_a(op_a),
    .op_b(op_b), .op_c(op_c), .op_mode(op_mode), .op_done(op_done), .busy(busy),
    .err_illegal(err_illegal)
  );

  typedef struct {
    logic [27:0] w;
    bit          is_mem;
    logic [11:0] base;
    int          len;
    bit          we;
    logic [1:0]  port;
    logic [2:0]  opc;
    logic [3:0]  a, b, c;
    logic [1:0]  mode;
    int          dly;
    bit          early;
  } vec_t;

  typedef struct { int cyc; logic [11:0] addr; logic we; logic [1:0] port; logic last; } beat_t;
  typedef struct { int cyc; logic [2:0] code; logic [3:0] a, b, c; logic [1:0] mode; } op_t;

  localparam int NV = 8;
  vec_t        vt [NV];
  int          n_chk = 0, n_fail = 0, cyc = 0, ack_cnt = -1, ack_dly = 0;
  int          force_done_cyc = -1, n_acc = 0, last_acc = 0;
  logic [27:0] send_q [$];
  beat_t       beat_q [$];
  op_t         op_q [$];
  logic        busy_log [4096];
  logic        ready_log [4096];

  function automatic logic [27:0] mk_mem(logic [2:0] opc, logic [11:0] ad, logic [5:0] ln,
                                         logic [1:0] pt);
    return {opc, ad, ln, pt, 5'b0};
  endfunction

  function automatic logic [27:0] mk_cmp(logic [2:0] opc, logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c, logic [1:0] md);
    return {opc, a, b, c, md, 11'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: sample outputs mid-cycle, then drive op_done and the next queued word.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc < 4096) begin
      busy_log[cyc]  = busy;
      ready_log[cyc] = inst_ready;
    end
    if (mem_en)   beat_q.push_back('{cyc, mem_addr, mem_we, mem_port, mem_last});
    if (op_valid) op_q.push_back('{cyc, op_code, op_a, op_b, op_c, op_mode});
    op_done = 1'b0;
    if (op_valid) ack_cnt = ack_dly;
    if (ack_cnt == 0) op_done = 1'b1;
    if (ack_cnt >= 0) ack_cnt--;
    if (cyc == force_done_cyc) op_done = 1'b1;
    if (send_q.size() > 0) begin
      inst       = send_q[0];
      inst_valid = 1'b1;
      if (inst_ready) begin
        void'(send_q.pop_front());
        n_acc++;
        last_acc = cyc;
      end
    end else begin
      inst_valid = 1'b0;
    end
  endtask

  task automatic clr_logs();
    beat_q.delete();
    op_q.delete();
    force_done_cyc = -1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " mem_en"}, 32'(mem_en), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " mem_last"}, 32'(mem_last), 0);
    chk({tag, " op_valid"}, 32'(op_valid), 0);
    chk({tag, " op_fields"}, 32'({op_code, op_a, op_b, op_c, op_mode}), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " err_illegal"}, 32'(err_illegal), 0);
    chk({tag, " inst_ready"}, 32'(inst_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, endc, c, a0;
    logic [11:0] ea;

    vt[0] = '{mk_mem(3'b000, 12'd100, 6'd4, 2'd0), 1, 12'd100, 4, 0, 2'd0, 3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    vt[1] = '{mk_mem(3'b001, 12'd4094, 6'd3, 2'd2), 1, 12'd4094, 3, 1, 2'd2, 3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    vt[2] = '{mk_cmp(3'b100, 4'd1, 4'd2, 4'd3, 2'd0), 0, 12'd0, 0, 0, 2'd0, 3'b100, 4'd1, 4'd2, 4'd3, 2'd0, 10, 0};
    vt[3] = '{mk_cmp(3'b101, 4'd15, 4'd0, 4'd7, 2'd3), 0, 12'd0, 0, 0, 2'd0, 3'b101, 4'd15, 4'd0, 4'd7, 2'd3, 0, 0};
    vt[4] = '{mk_cmp(3'b110, 4'd4, 4'd5, 4'd6, 2'd2), 0, 12'd0, 0, 0, 2'd0, 3'b110, 4'd4, 4'd5, 4'd6, 2'd2, 3, 1};
    vt[5] = '{mk_mem(3'b000, 12'd4095, 6'd1, 2'd3), 1, 12'd4095, 1, 0, 2'd3, 3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    vt[6] = '{mk_mem(3'b000, 12'd50, 6'd0, 2'd1), 1, 12'd50, 0, 0, 2'd1, 3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    vt[7] = '{mk_mem(3'b001, 12'd4060, 6'd63, 2'd1), 1, 12'd4060, 63, 1, 2'd1, 3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};

    repeat (3) tick();
    chk_reset_state("reset");
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      clr_logs();
      ack_dly = vt[i].dly;
      send_q.push_back(vt[i].w);
      tick();
      acc = last_acc;
      if (vt[i].early) force_done_cyc = acc + 2;
      repeat (vt[i].len + vt[i].dly + 8) tick();
      if (vt[i].is_mem) begin
        chk($sformatf("v%0d beats", i), beat_q.size(), vt[i].len);
        chk($sformatf("v%0d ops", i), op_q.size(), 0);
        for (int k = 0; k < beat_q.size() && k < vt[i].len; k++) begin
          ea = vt[i].base + 12'(k);
          chk($sformatf("v%0d b%0d addr", i, k), 32'(beat_q[k].addr), 32'(ea));
          chk($sformatf("v%0d b%0d cycle", i, k), beat_q[k].cyc, acc + 3 + k);
          chk($sformatf("v%0d b%0d we", i, k), 32'(beat_q[k].we), 32'(vt[i].we));
          chk($sformatf("v%0d b%0d port", i, k), 32'(beat_q[k].port), 32'(vt[i].port));
          chk($sformatf("v%0d b%0d last", i, k), 32'(beat_q[k].last), 32'(k == vt[i].len - 1));
        end
        endc = acc + 3 + vt[i].len;
      end else begin
        chk($sformatf("v%0d beats", i), beat_q.size(), 0);
        chk($sformatf("v%0d ops", i), op_q.size(), 1);
        if (op_q.size() > 0) begin
          chk($sformatf("v%0d op cycle", i), op_q[0].cyc, acc + 3);
          chk($sformatf("v%0d op_code", i), 32'(op_q[0].code), 32'(vt[i].opc));
          chk($sformatf("v%0d op_abc", i), 32'({op_q[0].a, op_q[0].b, op_q[0].c}),
              32'({vt[i].a, vt[i].b, vt[i].c}));
          chk($sformatf("v%0d op_mode", i), 32'(op_q[0].mode), 32'(vt[i].mode));
        end
        endc = acc + 5 + vt[i].dly;
      end
      chk($sformatf("v%0d busy before retire", i), 32'(busy_log[endc-1]), 1);
      chk($sformatf("v%0d busy after retire", i), 32'(busy_log[endc]), 0);
    end

    // Compute holds off a queued load until op_done, fields held while waiting.
    clr_logs();
    ack_dly = 10;
    send_q.push_back(mk_cmp(3'b100, 4'd1, 4'd2, 4'd3, 2'd0));
    send_q.push_back(mk_mem(3'b000, 12'd200, 6'd2, 2'd0));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (op_q.size() == 1 && cyc == op_q[0].cyc + 5) begin
        chk("A wait op_valid", 32'(op_valid), 0);
        chk("A wait fields", 32'({op_code, op_a, op_b, op_c, op_mode}),
            32'({3'b100, 4'd1, 4'd2, 4'd3, 2'd0}));
      end
    end
    chk("A ops", op_q.size(), 1);
    chk("A beats", beat_q.size(), 2);
    if (op_q.size() == 1 && beat_q.size() == 2) begin
      chk("A load start", beat_q[0].cyc, op_q[0].cyc + 13);
      chk("A load addr", 32'(beat_q[1].addr), 201);
    end

    // Six words pushed back to back while a compute stalls in WAIT.
    clr_logs();
    ack_dly = 20;
    send_q.push_back(mk_cmp(3'b110, 4'd9, 4'd8, 4'd7, 2'd1));
    for (int i = 0; i < 10 && op_q.size() == 0; i++) tick();
    chk("B stall op seen", op_q.size(), 1);
    c  = (op_q.size() > 0) ? op_q[0].cyc : cyc;
    a0 = n_acc;
    for (int j = 0; j < 6; j++) send_q.push_back(mk_mem(3'b000, 12'(1000 + 16 * j), 6'd2, 2'(j)));
    repeat (8) tick();
    chk("B accepts while full", n_acc - a0, 4);
    chk("B ready when full", 32'(inst_ready), 0);
    repeat (60) tick();
    chk("B accepts total", n_acc - a0, 6);
    chk("B ready before pop", 32'(ready_log[c+21]), 0);
    chk("B ready after pop", 32'(ready_log[c+22]), 1);
    chk("B beats", beat_q.size(), 12);
    for (int k = 0; k < beat_q.size() && k < 12; k++)
      chk($sformatf("B beat%0d addr", k), 32'(beat_q[k].addr), 1000 + 16 * (k / 2) + (k % 2));

    // Illegal opcode, zero-length load, then a two-beat load.
    clr_logs();
    chk("C err before", 32'(err_illegal), 0);
    send_q.push_back(mk_cmp(3'b111, 4'd1, 4'd1, 4'd1, 2'd1));
    send_q.push_back(mk_mem(3'b000, 12'd600, 6'd0, 2'd0));
    send_q.push_back(mk_mem(3'b000, 12'd300, 6'd2, 2'd1));
    repeat (15) tick();
    chk("C err set", 32'(err_illegal), 1);
    chk("C ops", op_q.size(), 0);
    chk("C beats", beat_q.size(), 2);
    if (beat_q.size() == 2) begin
      chk("C beat0 addr", 32'(beat_q[0].addr), 300);
      chk("C beat1 addr", 32'(beat_q[1].addr), 301);
      chk("C last", 32'({beat_q[0].last, beat_q[1].last}), 1);
    end
    repeat (5) tick();
    chk("C err sticky", 32'(err_illegal), 1);

    // Reset in the middle of an 8-beat load.
    clr_logs();
    send_q.push_back(mk_mem(3'b000, 12'd500, 6'd8, 2'd0));
    for (int i = 0; i < 10 && beat_q.size() < 2; i++) tick();
    chk("D beats before reset", beat_q.size(), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("D");
    repeat (12) tick();
    chk("D no beats after reset", beat_q.size(), 2);
    chk("D busy idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_dispatch.md
# inst_dispatch

Receive-side instruction front end for the accelerator `Top`. It accepts 28-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It executes the words in order: memory-transfer instructions become per-cycle address bursts, and compute instructions are handed to the matrix/encode units with a start/done handshake. It is the consumer of the instruction stream that the testbench and host controller produce.

## Interface
- INST_WIDTH, 28, instruction word width (fixed format below)
- ADDR_WIDTH, 12, memory address width
- FIFO_DEPTH, 4, instruction buffer entries (power of two)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  INST_WIDTH  instruction word
- inst_valid  in  1  inst is valid this cycle
- inst_ready  out  1  buffer can accept; high iff FIFO not full
- mem_en  out  1  address beat valid
- mem_we  out  1  beat is a store (opcode 001)
- mem_addr  out  ADDR_WIDTH  beat address
- mem_port  out  2  target port of the beat
- mem_last  out  1  final beat of the burst
- op_valid  out  1  one-cycle compute start pulse
- op_code  out  3  compute opcode
- op_a, op_b, op_c  out  4 each  operand / result buffer indices
- op_mode  out  2  compute mode
- op_done  in  1  compute unit finished
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_illegal  out  1  sticky; an illegal opcode was popped

## Operation
- Field layout:
  - Memory format: opcode[27:25], addr[24:13], length[12:7], port[6:5], [4:0] ignored.
  - Compute format: opcode[27:25], A[24:21], B[20:17], C[16:13], mode[12:11], [10:0] ignored.
- Opcodes:
  - 000 load, 001 store: memory burst.
  - 100, 101, 110: compute.
  - 010, 011, 111: illegal.
- FIFO push on inst_valid && inst_ready. Push is blocked when full, even if a pop happens the same cycle.
- FSM states IDLE, MEM, DISPATCH, WAIT.
- IDLE: if FIFO is non-empty, pop the head. Next state depends on the opcode:
  - Memory with length>0: MEM.
  - Memory with length==0: stay in IDLE; the instruction retires with no beats.
  - Compute: DISPATCH.
  - Illegal: set err_illegal and stay in IDLE; the word is discarded.
- MEM:
  - Each cycle, mem_en=1 and mem_addr = base+k for beat k=0..length-1.
  - The address wraps modulo 2^ADDR_WIDTH (4095+1 -> 0).
  - mem_last=1 on beat length-1, then go to IDLE.
- DISPATCH: op_valid=1 for exactly one cycle with the op_* fields held, then go to WAIT.
- WAIT: op_* fields stay held and op_valid=0. On op_done=1, go to IDLE.
- op_done is ignored in every state other than WAIT, including the DISPATCH cycle.
- Instructions complete strictly in order; there is no overlap between instructions.

## Timing
- Reset (on any clk edge with rst=1, including mid-burst or in WAIT):
  - FIFO is emptied and the FSM goes to IDLE.
  - Outputs go to 0: mem_en, mem_we, mem_addr, mem_port, mem_last, op_*, busy, err_illegal.
  - inst_ready goes to 1 in the first cycle after reset.
  - A burst in progress is abandoned with no further beats.
- All outputs except inst_ready are registered.
- Latency (empty FIFO, IDLE):
  - Word accepted at edge T, popped at T+1.
  - First mem_en or op_valid is visible after edge T+2.
- Burst of length L occupies L consecutive mem_en cycles. The next pop occurs in the cycle after mem_last, so there is one idle cycle between instructions.
- Compute: WAIT lasts until op_done. The earliest return to IDLE is the cycle after op_valid when op_done=1 there.
- inst_ready is combinational from the FIFO count only.
  - Full at 4 entries: ready=0.
  - The cycle after a pop from full: ready=1.
- busy drops in the cycle after the last instruction retires with the FIFO empty.

## Test plan
- Load, addr=100, len=4, port=0 (single word) -> mem_en high for 4 cycles:
  - Addresses 100, 101, 102, 103, mem_we=0, mem_last only on 103.
  - First beat 2 cycles after acceptance.
- Store, addr=4094, len=3, port=2 -> addresses 4094, 4095, 0, mem_we=1, mem_port=2.
- Compute 100, A=1, B=2, C=3, mode=0, with op_done returned 10 cycles after op_valid:
  - One op_valid pulse with the fields held.
  - The next queued load starts only after op_done.
- Six back-to-back words with inst_valid held, while a compute is stalled in WAIT:
  - inst_ready deasserts after 4 accepts.
  - All six execute in order, none lost or duplicated.
- Illegal opcode 111 followed by load len=0 and load len=2 -> err_illegal=1 (sticky); no beats for len=0; 2 beats for the last load.
- rst asserted on beat 2 of a len=8 load -> next cycle:
  - mem_en=0, busy=0, inst_ready=1.
  - No further beats.
